// File: rtl/stack_ptr_unit.sv
// stack_ptr_unit: bounded stack pointer with a shadow LIFO for save/restore
// and sticky range/shadow fault flags.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   op[2:0]          000 NOP, 001 CLR, 010 INC, 011 DEC,
//                    100 LD, 101 ADD, 110 SAVE, 111 RESTORE
//   din[W-1:0]       LD value (unsigned) / ADD offset (two's complement)
//   r                output enable for sp_out (combinational)
//   flag_clr         clears the sticky flags on the next edge
//   sp_out           SP when r=1, else high-impedance
//   sp_q             SP, always driven
//   ovf/unf          SP would go below BOT / above TOP
//   shv/shu          shadow LIFO overflow / underflow
//   sh_cnt           shadow entries in use; sh_full, sh_empty decoded from it
module stack_ptr_unit #(
   parameter int unsigned W     = 8,
   parameter int unsigned TOP   = (1 << W) - 1,
   parameter int unsigned BOT   = 0,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    op,
   input  logic [W-1:0]  din,
   input  logic          r,
   input  logic          flag_clr,
   output logic [W-1:0]  sp_out,
   output logic [W-1:0]  sp_q,
   output logic          ovf,
   output logic          unf,
   output logic          shv,
   output logic          shu,
   output logic [CW-1:0] sh_cnt,
   output logic          sh_full,
   output logic          sh_empty
);

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_CLR = 3'b001;
   localparam logic [2:0] OP_INC = 3'b010;
   localparam logic [2:0] OP_DEC = 3'b011;
   localparam logic [2:0] OP_LD  = 3'b100;
   localparam logic [2:0] OP_ADD = 3'b101;
   localparam logic [2:0] OP_SAV = 3'b110;
   localparam logic [2:0] OP_RST = 3'b111;

   localparam logic [W-1:0]  TOP_V = TOP[W-1:0];
   localparam logic [W-1:0]  BOT_V = BOT[W-1:0];
   localparam logic [CW-1:0] DEP_V = DEPTH[CW-1:0];
   localparam logic signed [W+1:0] TOP_S = $signed({2'b00, TOP_V});
   localparam logic signed [W+1:0] BOT_S = $signed({2'b00, BOT_V});
   // Shadow array sized to the full counter range so sh_cnt indexes it
   // directly; entries at DEPTH and above are never written.
   localparam int unsigned NSH = 1 << CW;

   // Declaration initialisers give the same power-up state as reset.
   logic [W-1:0]  r_sp  = TOP_V;
   logic [CW-1:0] r_cnt = '0;
   logic          r_ovf = 1'b0;
   logic          r_unf = 1'b0;
   logic          r_shv = 1'b0;
   logic          r_shu = 1'b0;
   logic [W-1:0]  r_sh [NSH];

   logic signed [W+1:0] w_sum;
   logic [W-1:0]        w_sp_nxt;
   logic [CW-1:0]       w_cnt_nxt;
   logic                w_push;
   logic                w_set_ovf, w_set_unf, w_set_shv, w_set_shu;

   // ADD in W+2 bits so neither the unsigned SP nor the signed offset wraps.
   assign w_sum = $signed({2'b00, r_sp}) + $signed({{2{din[W-1]}}, din});

   always_comb begin
      w_sp_nxt  = r_sp;
      w_cnt_nxt = r_cnt;
      w_push    = 1'b0;
      w_set_ovf = 1'b0;
      w_set_unf = 1'b0;
      w_set_shv = 1'b0;
      w_set_shu = 1'b0;
      case (op)
         OP_NOP: ;
         OP_CLR: w_sp_nxt = TOP_V;
         OP_INC: begin
            if (r_sp == TOP_V) w_set_unf = 1'b1;
            else               w_sp_nxt  = r_sp + W'(1);
         end
         OP_DEC: begin
            if (r_sp == BOT_V) w_set_ovf = 1'b1;
            else               w_sp_nxt  = r_sp - W'(1);
         end
         OP_LD: begin
            if (din > TOP_V)      w_set_unf = 1'b1;
            else if (din < BOT_V) w_set_ovf = 1'b1;
            else                  w_sp_nxt  = din;
         end
         OP_ADD: begin
            if (w_sum > TOP_S)      w_set_unf = 1'b1;
            else if (w_sum < BOT_S) w_set_ovf = 1'b1;
            else                    w_sp_nxt  = w_sum[W-1:0];
         end
         OP_SAV: begin
            if (r_cnt < DEP_V) begin
               w_push    = 1'b1;
               w_cnt_nxt = r_cnt + CW'(1);
            end else begin
               w_set_shv = 1'b1;
            end
         end
         OP_RST: begin
            if (r_cnt != '0) begin
               w_sp_nxt  = r_sh[r_cnt - CW'(1)];
               w_cnt_nxt = r_cnt - CW'(1);
            end else begin
               w_set_shu = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // A fault raised in the same cycle as flag_clr survives (set wins).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sp  <= TOP_V;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
         r_shv <= 1'b0;
         r_shu <= 1'b0;
      end else begin
         r_sp  <= w_sp_nxt;
         r_cnt <= w_cnt_nxt;
         r_ovf <= (r_ovf & ~flag_clr) | w_set_ovf;
         r_unf <= (r_unf & ~flag_clr) | w_set_unf;
         r_shv <= (r_shv & ~flag_clr) | w_set_shv;
         r_shu <= (r_shu & ~flag_clr) | w_set_shu;
      end
   end

   // Shadow storage has no reset; stale entries are unreachable once sh_cnt=0.
   always_ff @(posedge clk) begin
      if (!reset && w_push) r_sh[r_cnt] <= r_sp;
   end

   assign sp_q     = r_sp;
   assign sp_out   = r ? r_sp : {W{1'bz}};
   assign ovf      = r_ovf;
   assign unf      = r_unf;
   assign shv      = r_shv;
   assign shu      = r_shu;
   assign sh_cnt   = r_cnt;
   assign sh_full  = (r_cnt == DEP_V);
   assign sh_empty = (r_cnt == '0);

endmodule

// File: tb/tb_stack_ptr_unit.sv
module tb_stack_ptr_unit;

   localparam int W = 8, TOP = 'hFF, BOT = 'hF0, DEPTH = 2, CW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [2:0]    op = 3'b000;
   logic [W-1:0]  din = '0;
   logic          r = 1'b0;
   logic          flag_clr = 1'b0;
   wire  [W-1:0]  sp_out;
   logic [W-1:0]  sp_q;
   logic          ovf, unf, shv, shu;
   logic [CW-1:0] sh_cnt;
   logic          sh_full, sh_empty;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int m_sp;
   int m_q[$];
   bit m_ovf, m_unf, m_shv, m_shu;

   stack_ptr_unit #(.W(W), .TOP(TOP), .BOT(BOT), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .op(op), .din(din), .r(r),
      .flag_clr(flag_clr), .sp_out(sp_out), .sp_q(sp_q),
      .ovf(ovf), .unf(unf), .shv(shv), .shu(shu),
      .sh_cnt(sh_cnt), .sh_full(sh_full), .sh_empty(sh_empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".sp"}, int'(sp_q), m_sp);
      chk({tag, ".flags"}, int'({ovf, unf, shv, shu}),
          int'({m_ovf, m_unf, m_shv, m_shu}));
      chk({tag, ".cnt"}, int'(sh_cnt), m_q.size());
      chk({tag, ".full_empty"}, int'({sh_full, sh_empty}),
          int'({m_q.size() == DEPTH, m_q.size() == 0}));
   endtask

   // Apply one operation for one clock and advance the model by the same rules.
   task automatic step(input logic [2:0] o, input int d, input bit fc);
      int s;
      bit so, su, sv, sh;
      @(negedge clk);
      op = o; din = W'(d); flag_clr = fc;
      @(posedge clk);
      so = 0; su = 0; sv = 0; sh = 0;
      case (o)
         3'd1: m_sp = TOP;
         3'd2: if (m_sp == TOP) su = 1; else m_sp = m_sp + 1;
         3'd3: if (m_sp == BOT) so = 1; else m_sp = m_sp - 1;
         3'd4: if (d > TOP) su = 1; else if (d < BOT) so = 1; else m_sp = d;
         3'd5: begin
            s = m_sp + ((d >= 128) ? d - 256 : d);
            if (s > TOP) su = 1; else if (s < BOT) so = 1; else m_sp = s;
         end
         3'd6: if (m_q.size() < DEPTH) m_q.push_back(m_sp); else sv = 1;
         3'd7: if (m_q.size() > 0) m_sp = m_q.pop_back(); else sh = 1;
         default: ;
      endcase
      if (fc) begin m_ovf = 0; m_unf = 0; m_shv = 0; m_shu = 0; end
      m_ovf |= so; m_unf |= su; m_shv |= sv; m_shu |= sh;
      #1;
   endtask

   task automatic do_reset(input logic [2:0] o);
      @(negedge clk);
      reset = 1'b1; op = o; flag_clr = 1'b1;
      @(posedge clk);
      m_sp = TOP; m_q.delete();
      m_ovf = 0; m_unf = 0; m_shv = 0; m_shu = 0;
      #1;
      @(negedge clk);
      reset = 1'b0; op = 3'd0; flag_clr = 1'b0;
   endtask

   initial begin
      int o, d;
      m_sp = TOP;
      // power-up state before any reset
      #1 chk_all("powerup");

      do_reset(3'd3);
      chk_all("reset");

      // DEC x3, output enable
      step(3'd3, 0, 0); step(3'd3, 0, 0); step(3'd3, 0, 0);
      chk_all("dec3");
      r = 1'b1; #1;
      chk("sp_out_en", int'(sp_out), 'hFC);
      r = 1'b0; #1;
      chk("sp_q_oe_off", int'(sp_q), 'hFC);

      // lower bound
      step(3'd4, 'hF0, 0); step(3'd3, 0, 0);
      chk_all("dec_at_bot");
      step(3'd2, 0, 0);
      chk_all("inc_keep_ovf");
      step(3'd0, 0, 1);
      chk_all("flag_clr");

      // ADD with signed offsets
      step(3'd4, 'hF8, 0); step(3'd5, 'hFA, 0);
      chk_all("add_neg6");
      step(3'd5, 'hF0, 0);
      chk_all("add_below_bot");
      step(3'd5, 'h7F, 0);
      chk_all("add_above_top");
      step(3'd0, 0, 1);

      // shadow LIFO
      step(3'd4, 'hF5, 0); step(3'd6, 0, 0);
      step(3'd4, 'hF9, 0); step(3'd6, 0, 0);
      step(3'd4, 'hF1, 0); step(3'd6, 0, 0);
      chk_all("save_full");
      step(3'd7, 0, 0); chk_all("restore1");
      step(3'd7, 0, 0); chk_all("restore2");
      step(3'd7, 0, 0); chk_all("restore_empty");

      // set wins over flag_clr
      step(3'd1, 0, 0); step(3'd2, 0, 0); step(3'd3, 0, 0); step(3'd3, 0, 0);
      step(3'd4, 'hF0, 0); step(3'd3, 0, 0); step(3'd1, 0, 0);
      step(3'd2, 0, 1);
      chk_all("set_wins");

      // reset overrides a pending DEC
      step(3'd4, 'hF3, 0); step(3'd6, 0, 0); step(3'd4, 'hF0, 0);
      step(3'd3, 0, 0); step(3'd4, 'hF3, 0);
      chk_all("pre_reset");
      do_reset(3'd3);
      chk_all("reset_with_dec");

      // randomized ops against the model
      for (int i = 0; i < 400; i++) begin
         o = int'($urandom_range(0, 7));
         d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 31)) + 'hE8;
         if (o == 5 && $urandom_range(0, 1) == 0)
            d = int'($urandom_range(0, 24)) ^ 'hFF;
         step(3'(o), d & 'hFF, ($urandom_range(0, 9) == 0));
         chk_all("rand");
         if ($urandom_range(0, 63) == 0) begin
            do_reset(3'(o));
            chk_all("rand_reset");
         end
         if ($urandom_range(0, 15) == 0) begin
            r = 1'b1; #1;
            chk("rand_sp_out", int'(sp_out), m_sp);
            r = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
